seg_memory: RTL and testbench
=============================

Name: seg_memory

Overview:
MEM stage of the 5-stage MIPS pipeline, consuming the EX/MEM outputs of the execute stage: ALU result, store data, destination register, WB+M control and branch target/zero.
- Resolves the branch (PCSrc) back to fetch.
- Performs word load/store into an internal data memory.
- Registers the MEM/WB pipeline stage for writeback.
- Clears its memory after reset via a small FSM and exposes a debug read port for the UART debug unit.

Parameters:
NB_ADDR, 32, PC/branch target width
NB_DATA, 32, data word width
NB_MEM_ADDR, 8, word-address bits; depth = 2**NB_MEM_ADDR words
NB_REG, 5, register-file index width
NB_CTRL_WB, 2, WB control bits
NB_CTRL_M, 3, M control bits

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, synchronous, active-low
i_enable  in  1  pipeline step enable from debug unit; 0 = freeze
i_PC  in  NB_ADDR  branch target from EX
i_ALU_result  in  NB_DATA  byte address / ALU value
i_ALU_zero  in  1  ALU zero flag
i_write_data  in  NB_DATA  store data (rt)
i_write_reg  in  NB_REG  destination register
i_control  in  NB_CTRL_WB+NB_CTRL_M  [4]RegWrite [3]MemtoReg [2]Branch [1]MemRead [0]MemWrite
i_debug_addr  in  NB_MEM_ADDR  debug word address
o_PC_src  out  1  take branch (combinational)
o_branch_target  out  NB_ADDR  = i_PC (combinational)
o_read_data  out  NB_DATA  MEM/WB load data
o_ALU_result  out  NB_DATA  MEM/WB ALU result
o_write_reg  out  NB_REG  MEM/WB destination
o_control  out  NB_CTRL_WB  MEM/WB {RegWrite,MemtoReg}
o_debug_data  out  NB_DATA  registered mem[i_debug_addr]
o_ready  out  1  1 when memory clear is done
o_misaligned  out  1  sticky misaligned-access flag

Behaviour:
- FSM states CLEAR and RUN.
  - Reset forces CLEAR with clear counter = 0.
  - CLEAR writes 0 to mem[counter] each cycle and increments the counter.
  - When counter = depth-1, the zero is written and the FSM moves to RUN. CLEAR lasts exactly 2**NB_MEM_ADDR cycles.
  - RUN is held until the next reset.
- Reset values: all MEM/WB registers, o_debug_data, o_misaligned = 0; o_ready = 0. o_ready rises in the first RUN cycle.
- Effective step: step = i_enable & o_ready. In CLEAR, i_enable and all M/WB control are ignored.
- Address: word index = i_ALU_result[NB_MEM_ADDR+1:2]. Upper bits are ignored (wrap-around). Misaligned = i_ALU_result[1:0] != 0.
- Store: when step & MemWrite & !misaligned, mem[idx] <= i_write_data at the clock edge.
- Load: when step, o_read_data <= (MemRead & !misaligned) ? mem[idx] : 0. Data is visible the cycle after presentation (1-cycle latency, same as the other MEM/WB fields).
- MemRead and MemWrite set together: the write happens and the load returns the pre-write (old) value.
- MEM/WB register: on step, latch i_ALU_result, i_write_reg and i_control[4:3]. On !step, hold all values.
- Misaligned handling: when step & (MemRead|MemWrite) & misaligned, o_misaligned <= 1 (sticky until reset). The store is suppressed and the load yields 0.
- Branch: o_PC_src = Branch & i_ALU_zero & step. o_branch_target = i_PC, always passed through.
- Debug port: o_debug_data <= mem[i_debug_addr] every cycle, independent of step. During CLEAR it reflects partially cleared contents.
- Reset mid-operation: any cycle with i_rst = 0 restarts CLEAR. In-flight stores are dropped.

Decomposition:
- Shared package:
  - control bit indices (RegWrite = 4, MemtoReg = 3, Branch = 2, MemRead = 1, MemWrite = 0);
  - NB_CTRL_WB/NB_CTRL_M;
  - FSM state encoding.
- One sub-module, seg_memory_ram: single write port, synchronous read port, plus a second synchronous debug read port. Mux of CLEAR/RUN write signals stays in the top level.

Test Plan:
- Reset, hold i_rst=0 for 2 cycles, release -> o_ready=0 for 256 cycles then 1; debug reads of addr 0, 255 return 0.
- Store 0xDEADBEEF at address 0x10 with MemWrite, then load 0x10 -> o_read_data = 0xDEADBEEF one cycle after the load is presented; o_debug_data at debug addr 4 = 0xDEADBEEF.
- MemRead & MemWrite at 0x20 (old value 0x11111111, new 0x22222222) -> o_read_data = 0x11111111; a later load returns 0x22222222.
- Store at address 0x13 -> memory unchanged, o_misaligned = 1 and stays 1; a load at 0x13 gives o_read_data = 0.
- Branch=1, zero=1, i_PC=0x40 -> o_PC_src = 1, o_branch_target = 0x40. With zero=0 or i_enable=0 -> o_PC_src = 0.
- i_enable=0 with MemWrite at 0x30 -> no write, MEM/WB outputs hold. Store during CLEAR -> ignored, address still 0 after RUN.

Source files
------------

// File: rtl/seg_memory_pkg.sv
// seg_memory_pkg: shared control-bit indices, control widths and FSM encoding for the MEM stage.
package seg_memory_pkg;

    localparam int NB_CTRL_WB = 2;
    localparam int NB_CTRL_M  = 3;

    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/seg_memory_ram.sv
// seg_memory_ram: word RAM with one write port, an enabled synchronous read port and a free-running debug read port.
module seg_memory_ram
    import seg_memory_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_rd_en,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];
    logic [NB_DATA-1:0] rdata_q;
    logic [NB_DATA-1:0] dbg_q;

    always_ff @(posedge i_clk) begin
        if (i_we)
            mem[i_waddr] <= i_wdata;
    end

    // Reads sample the array before this edge's write lands, so a combined read/write returns the old word.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rdata_q <= '0;
            dbg_q   <= '0;
        end else begin
            if (i_rd_en)
                rdata_q <= mem[i_raddr];
            dbg_q <= mem[i_dbg_addr];
        end
    end

    assign o_rdata    = rdata_q;
    assign o_dbg_data = dbg_q;

endmodule

// File: rtl/seg_memory.sv
// seg_memory: MIPS MEM stage -- branch resolve, word load/store, MEM/WB register, post-reset memory clear and debug read.
module seg_memory
    import seg_memory_pkg::*;
#(
    parameter int NB_ADDR     = 32,
    parameter int NB_DATA     = 32,
    parameter int NB_MEM_ADDR = 8,
    parameter int NB_REG      = 5,
    parameter int NB_CTRL_WB  = seg_memory_pkg::NB_CTRL_WB,
    parameter int NB_CTRL_M   = seg_memory_pkg::NB_CTRL_M
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic [NB_ADDR-1:0]              i_PC,
    input  logic [NB_DATA-1:0]              i_ALU_result,
    input  logic                            i_ALU_zero,
    input  logic [NB_DATA-1:0]              i_write_data,
    input  logic [NB_REG-1:0]               i_write_reg,
    input  logic [NB_CTRL_WB+NB_CTRL_M-1:0] i_control,
    input  logic [NB_MEM_ADDR-1:0]          i_debug_addr,
    output logic                            o_PC_src,
    output logic [NB_ADDR-1:0]              o_branch_target,
    output logic [NB_DATA-1:0]              o_read_data,
    output logic [NB_DATA-1:0]              o_ALU_result,
    output logic [NB_REG-1:0]               o_write_reg,
    output logic [NB_CTRL_WB-1:0]           o_control,
    output logic [NB_DATA-1:0]              o_debug_data,
    output logic                            o_ready,
    output logic                            o_misaligned
);

    state_e                 state_q;
    logic [NB_MEM_ADDR-1:0] cnt_q;
    logic                   ready_q;

    logic                   step;
    logic                   misaligned;
    logic                   mem_read;
    logic                   mem_write;
    logic [NB_MEM_ADDR-1:0] idx;

    logic                   ram_we;
    logic [NB_MEM_ADDR-1:0] ram_waddr;
    logic [NB_DATA-1:0]     ram_wdata;
    logic [NB_DATA-1:0]     ram_rdata;

    logic [NB_DATA-1:0]     alu_q, alu_d;
    logic [NB_REG-1:0]      reg_q, reg_d;
    logic [NB_CTRL_WB-1:0]  ctrl_q, ctrl_d;
    logic                   ld_q, ld_d;
    logic                   mis_q, mis_d;

    assign step       = i_enable & ready_q;
    assign idx        = i_ALU_result[NB_MEM_ADDR+1:2];
    assign misaligned = |i_ALU_result[1:0];
    assign mem_read   = i_control[CTRL_MEMREAD];
    assign mem_write  = i_control[CTRL_MEMWRITE];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == {NB_MEM_ADDR{1'b1}}) begin
                state_q <= ST_RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Clearing owns the write port; a cycle in reset writes nothing so in-flight stores are dropped.
    always_comb begin
        ram_we    = !i_rst ? 1'b0 : (state_q == ST_CLEAR) ? 1'b1 : step & mem_write & !misaligned;
        ram_waddr = (state_q == ST_CLEAR) ? cnt_q : idx;
        ram_wdata = (state_q == ST_CLEAR) ? '0 : i_write_data;
    end

    seg_memory_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_MEM_ADDR)
    ) u_ram (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (ram_we),
        .i_waddr    (ram_waddr),
        .i_wdata    (ram_wdata),
        .i_rd_en    (step),
        .i_raddr    (idx),
        .o_rdata    (ram_rdata),
        .i_dbg_addr (i_debug_addr),
        .o_dbg_data (o_debug_data)
    );

    always_comb begin
        alu_d  = step ? i_ALU_result : alu_q;
        reg_d  = step ? i_write_reg : reg_q;
        ctrl_d = step ? i_control[CTRL_REGWRITE:CTRL_MEMTOREG] : ctrl_q;
        ld_d   = step ? mem_read & !misaligned : ld_q;
        mis_d  = mis_q | (step & (mem_read | mem_write) & misaligned);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            alu_q  <= '0;
            reg_q  <= '0;
            ctrl_q <= '0;
            ld_q   <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            reg_q  <= reg_d;
            ctrl_q <= ctrl_d;
            ld_q   <= ld_d;
            mis_q  <= mis_d;
        end
    end

    // RAM read register holds with step, so gating it by the latched load flag yields the zero for non-loads.
    assign o_read_data     = ld_q ? ram_rdata : '0;
    assign o_ALU_result    = alu_q;
    assign o_write_reg     = reg_q;
    assign o_control       = ctrl_q;
    assign o_ready         = ready_q;
    assign o_misaligned    = mis_q;
    assign o_PC_src        = i_control[CTRL_BRANCH] & i_ALU_zero & step;
    assign o_branch_target = i_PC;

endmodule

// File: tb/tb_seg_memory.sv
// tb_seg_memory: directed self-checking bench for the seg_memory MEM stage.
module tb_seg_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] alu = '0;
    logic        zero = 1'b0;
    logic [31:0] wdata = '0;
    logic [4:0]  wreg = '0;
    logic [4:0]  ctrl = '0;
    logic [7:0]  dbg_addr = '0;
    logic        pc_src;
    logic [31:0] target;
    logic [31:0] rdata;
    logic [31:0] alu_o;
    logic [4:0]  wreg_o;
    logic [1:0]  ctrl_o;
    logic [31:0] dbg_data;
    logic        ready;
    logic        mis;

    int n_chk = 0;
    int n_err = 0;
    int cycles;

    seg_memory dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_enable        (enable),
        .i_PC            (pc),
        .i_ALU_result    (alu),
        .i_ALU_zero      (zero),
        .i_write_data    (wdata),
        .i_write_reg     (wreg),
        .i_control       (ctrl),
        .i_debug_addr    (dbg_addr),
        .o_PC_src        (pc_src),
        .o_branch_target (target),
        .o_read_data     (rdata),
        .o_ALU_result    (alu_o),
        .o_write_reg     (wreg_o),
        .o_control       (ctrl_o),
        .o_debug_data    (dbg_data),
        .o_ready         (ready),
        .o_misaligned    (mis)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        ctrl  = c;
        alu   = a;
        wdata = d;
        wreg  = r;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_alu", alu_o, 32'd0);
        check("rst_mis", {31'b0, mis}, 32'd0);
        check("rst_dbg", dbg_data, 32'd0);
        // Attempt a store and a branch throughout CLEAR; both must be ignored.
        enable = 1'b1;
        ctrl   = 5'b11101;
        alu    = 32'h0000_0000;
        wdata  = 32'hBAD0_BAD0;
        wreg   = 5'd9;
        zero   = 1'b1;
        #1;
        check("clr_pcsrc", {31'b0, pc_src}, 32'd0);
        rst    = 1'b1;
        cycles = 0;
        while (!ready && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("clear_cycles", cycles, 32'd256);
        check("clr_alu_hold", alu_o, 32'd0);
        check("clr_reg_hold", {27'b0, wreg_o}, 32'd0);
        ctrl     = '0;
        zero     = 1'b0;
        dbg_addr = 8'd0;
        tick();
        check("dbg_addr0", dbg_data, 32'd0);
        dbg_addr = 8'd255;
        tick();
        check("dbg_addr255", dbg_data, 32'd0);

        op(5'b00001, 32'h10, 32'hDEAD_BEEF, 5'd1);
        dbg_addr = 8'd4;
        op(5'b11010, 32'h10, 32'h0, 5'd7);
        check("ld_data", rdata, 32'hDEAD_BEEF);
        check("ld_alu", alu_o, 32'h10);
        check("ld_reg", {27'b0, wreg_o}, 32'd7);
        check("ld_ctrl", {30'b0, ctrl_o}, 32'd3);
        check("dbg_addr4", dbg_data, 32'hDEAD_BEEF);

        op(5'b00001, 32'h20, 32'h1111_1111, 5'd0);
        op(5'b00011, 32'h20, 32'h2222_2222, 5'd0);
        check("rmw_old", rdata, 32'h1111_1111);
        op(5'b00010, 32'h20, 32'h0, 5'd0);
        check("rmw_new", rdata, 32'h2222_2222);

        op(5'b00001, 32'h408, 32'h5A5A_5A5A, 5'd0);
        dbg_addr = 8'd2;
        tick();
        check("wrap_store", dbg_data, 32'h5A5A_5A5A);

        check("mis_before", {31'b0, mis}, 32'd0);
        op(5'b00001, 32'h13, 32'hCAFE_F00D, 5'd0);
        check("mis_set", {31'b0, mis}, 32'd1);
        dbg_addr = 8'd4;
        op(5'b00010, 32'h13, 32'h0, 5'd3);
        check("mis_noStore", dbg_data, 32'hDEAD_BEEF);
        check("mis_ld_zero", rdata, 32'd0);
        op(5'b00000, 32'h0, 32'h0, 5'd0);
        check("mis_sticky", {31'b0, mis}, 32'd1);
        op(5'b00010, 32'h13, 32'h0, 5'd3);

        ctrl = 5'b00100;
        zero = 1'b1;
        pc   = 32'h40;
        #1;
        check("br_taken", {31'b0, pc_src}, 32'd1);
        check("br_target", target, 32'h40);
        zero = 1'b0;
        #1;
        check("br_nozero", {31'b0, pc_src}, 32'd0);
        zero   = 1'b1;
        enable = 1'b0;
        #1;
        check("br_noen", {31'b0, pc_src}, 32'd0);
        zero = 1'b0;

        op(5'b11001, 32'h30, 32'h3333_3333, 5'd9);
        check("frz_alu", alu_o, 32'h13);
        check("frz_reg", {27'b0, wreg_o}, 32'd3);
        check("frz_ctrl", {30'b0, ctrl_o}, 32'd0);
        check("frz_rdata", rdata, 32'd0);
        enable   = 1'b1;
        dbg_addr = 8'd12;
        op(5'b00010, 32'h30, 32'h0, 5'd0);
        check("frz_noStore", rdata, 32'd0);
        check("frz_dbg", dbg_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
